ram_access_controller: RTL and testbench



---
 rtl/ram_ctrl_pkg.sv | 21 ++
 rtl/ram_access_controller_if.sv | 27 ++
 rtl/sync_fifo.sv | 48 ++++
 rtl/ram_access_controller.sv | 147 ++++++++++++++
 tb/tb_ram_access_controller.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the data-RAM access controller.
//   DEF_* : default geometry of the 2048 x 32 data RAM
//   req_t : one request at the default geometry {write, addr, wdata}
//   issue_state_e : per-cycle state of the ISSUE slot
package ram_ctrl_pkg;
  localparam int DEF_ADDR_W     = 11;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_MEM_WORDS  = 2048;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef struct packed {
    logic                  write;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } req_t;

  typedef enum logic {
    ISSUE_IDLE   = 1'b0,
    ISSUE_ACTIVE = 1'b1
  } issue_state_e;
endpackage

// File: rtl/ram_access_controller_if.sv
// Request/response bus between the CPU/bus side and the RAM controller.
//   req_*  : valid/ready request channel (master drives valid/write/addr/wdata)
//   resp_* : response pulse channel, no backpressure (slave drives)
interface ram_access_controller_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_write;
  logic              resp_error;
  logic [DATA_W-1:0] resp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_write, resp_error, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_write, resp_error, resp_rdata
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous active-high reset.
//   push/din  : write when push and not full
//   pop/dout  : dout is the current head; pop advances it when not empty
//   full/empty/count : occupancy
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset: entries are only read once count covers them.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/ram_access_controller.sv
// Sequencing front-end for the word-addressed data RAM.
//   clock, reset : rising-edge clock (RAM works on the falling edge), sync reset
//   bus          : request/response channel (slave side)
//   ram_*        : registered RAM pins; ram_data_out floats when deselected
// Pipeline: request FIFO -> ISSUE register (drives the RAM pins) ->
// RESPONSE register. One access per cycle, fixed 2-cycle latency from an
// empty FIFO, responses strictly in request order.
module ram_access_controller
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int MEM_WORDS  = DEF_MEM_WORDS
) (
  input  logic                  clock,
  input  logic                  reset,
  ram_access_controller_if.slave bus,
  output logic [ADDR_W-1:0]     ram_address,
  output logic [DATA_W-1:0]     ram_data_in,
  output logic                  ram_we,
  output logic                  ram_chip_select,
  input  logic [DATA_W-1:0]     ram_data_out
);
  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } fifo_req_t;

  localparam int REQ_W = $bits(fifo_req_t);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  // One extra bit so MEM_WORDS == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W + 1)'(MEM_WORDS);

  fifo_req_t        push_req, head;
  logic             push, pop;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count, count_nxt;
  logic             req_ready_q;
  logic             head_in_range;

  assign push_req = '{write: bus.req_write, addr: bus.req_addr, wdata: bus.req_wdata};
  assign push     = bus.req_valid & req_ready_q & ~fifo_full;
  // The ISSUE slot never stalls, so the head is taken whenever present.
  assign pop      = ~fifo_empty;

  sync_fifo #(.WIDTH(REQ_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .din   (push_req),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // req_ready is a register, computed from the occupancy after this edge,
  // so it is low in the cycle following reset and the bus sees no comb path.
  assign count_nxt = fifo_count + CNT_W'(push) - CNT_W'(pop);

  always_ff @(posedge clock) begin
    if (reset) req_ready_q <= 1'b0;
    else       req_ready_q <= (count_nxt != CNT_W'(FIFO_DEPTH));
  end

  assign bus.req_ready = req_ready_q;

  // ---------------- ISSUE stage ----------------
  issue_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] data_d;
  logic              we_d, cs_d;
  logic              issue_write_q, issue_write_d;
  logic              issue_err_q, issue_err_d;

  assign head_in_range = ({1'b0, head.addr} < MEM_LIMIT);

  always_comb begin
    state_d       = ISSUE_IDLE;
    addr_d        = ram_address;
    data_d        = ram_data_in;
    we_d          = 1'b0;
    cs_d          = 1'b0;
    issue_write_d = issue_write_q;
    issue_err_d   = issue_err_q;
    if (!fifo_empty) begin
      state_d       = ISSUE_ACTIVE;
      addr_d        = head.addr;
      data_d        = head.wdata;
      // Out-of-range entries occupy the slot but never touch the RAM.
      cs_d          = head_in_range;
      we_d          = head.write & head_in_range;
      issue_write_d = head.write;
      issue_err_d   = ~head_in_range;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= ISSUE_IDLE;
      ram_address     <= '0;
      ram_data_in     <= '0;
      ram_we          <= 1'b0;
      ram_chip_select <= 1'b0;
      issue_write_q   <= 1'b0;
      issue_err_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      ram_address     <= addr_d;
      ram_data_in     <= data_d;
      ram_we          <= we_d;
      ram_chip_select <= cs_d;
      issue_write_q   <= issue_write_d;
      issue_err_q     <= issue_err_d;
    end
  end

  // ---------------- RESPONSE stage ----------------
  logic              resp_valid_q, resp_write_q, resp_error_q;
  logic [DATA_W-1:0] resp_rdata_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      resp_valid_q <= 1'b0;
      resp_write_q <= 1'b0;
      resp_error_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      resp_valid_q <= (state_q == ISSUE_ACTIVE);
      if (state_q == ISSUE_ACTIVE) begin
        resp_write_q <= issue_write_q;
        resp_error_q <= issue_err_q;
        // Only sample the RAM when it was selected for a read; otherwise its
        // data_out is floating.
        resp_rdata_q <= (ram_chip_select && !ram_we) ? ram_data_out : '0;
      end
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_write = resp_write_q;
  assign bus.resp_error = resp_error_q;
  assign bus.resp_rdata = resp_rdata_q;
endmodule

// File: tb/tb_ram_access_controller.sv
module tb_ram_access_controller;
  import ram_ctrl_pkg::*;

  localparam int AW = 11;
  localparam int DW = 32;
  localparam int DEPTH = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  ram_access_controller_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  ram_access_controller_if #(.ADDR_W(AW), .DATA_W(DW)) bus_s ();

  logic [AW-1:0] ram_address, s_ram_address;
  logic [DW-1:0] ram_data_in, s_ram_data_in;
  logic          ram_we, ram_chip_select, s_ram_we, s_ram_chip_select;
  logic [DW-1:0] ram_data_out;
  wire  [DW-1:0] s_ram_data_out = 'z;

  ram_access_controller #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .MEM_WORDS(2048)) u_dut (
    .clock(clock), .reset(reset), .bus(bus),
    .ram_address(ram_address), .ram_data_in(ram_data_in), .ram_we(ram_we),
    .ram_chip_select(ram_chip_select), .ram_data_out(ram_data_out));

  // Second instance with only 1024 implemented words; its RAM never drives.
  ram_access_controller #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .MEM_WORDS(1024)) u_dut_small (
    .clock(clock), .reset(reset), .bus(bus_s),
    .ram_address(s_ram_address), .ram_data_in(s_ram_data_in), .ram_we(s_ram_we),
    .ram_chip_select(s_ram_chip_select), .ram_data_out(s_ram_data_out));

  // RAM device: acts on the falling edge, floats data_out unless reading.
  logic [DW-1:0] ram_mem [2048];
  logic [DW-1:0] ram_dout;
  assign ram_data_out = ram_dout;
  always @(negedge clock) begin
    if (ram_chip_select && !ram_we) ram_dout <= ram_mem[ram_address];
    else                            ram_dout <= 'z;
    if (ram_chip_select && ram_we)  ram_mem[ram_address] <= ram_data_in;
  end

  // Reference model: every accepted request answers 2 cycles after
  // acceptance, or one cycle after the previous answer, whichever is later.
  typedef struct {
    req_t          req;
    logic          err;
    logic [DW-1:0] rdata;
    int            acc;
    int            due;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] ref_mem [2048];
  int            last_due = 0;
  int            cyc = 0;
  int            vectors = 0;
  int            miscompares = 0;
  bit            mon_en = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  // Per-cycle monitor of the main instance against the model.
  always @(negedge clock) begin : monitor
    logic          exp_cs, exp_we, exp_v;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_din;
    int            exp_cnt;
    if (mon_en) begin
      exp_cs = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_din = '0; exp_cnt = 0;
      foreach (q[i]) begin
        if (q[i].due - 1 == cyc) begin
          exp_cs   = !q[i].err;
          exp_we   = q[i].req.write && !q[i].err;
          exp_addr = q[i].req.addr;
          exp_din  = q[i].req.wdata;
        end
        if (q[i].acc <= cyc && q[i].due - 1 > cyc) exp_cnt++;
      end
      vectors += 3;
      if (ram_chip_select !== exp_cs) begin
        miscompares++; $display("FAIL chip_select cyc %0d: got %b want %b", cyc, ram_chip_select, exp_cs);
      end
      if (ram_we !== exp_we) begin
        miscompares++; $display("FAIL ram_we cyc %0d: got %b want %b", cyc, ram_we, exp_we);
      end
      if (bus.req_ready !== (exp_cnt != DEPTH)) begin
        miscompares++; $display("FAIL req_ready cyc %0d: got %b want %b", cyc, bus.req_ready, exp_cnt != DEPTH);
      end
      if (exp_cs) begin
        vectors++;
        if (ram_address !== exp_addr) begin
          miscompares++; $display("FAIL ram_address cyc %0d: got %0d want %0d", cyc, ram_address, exp_addr);
        end
      end
      if (exp_we) begin
        vectors++;
        if (ram_data_in !== exp_din) begin
          miscompares++; $display("FAIL ram_data_in cyc %0d: got %h want %h", cyc, ram_data_in, exp_din);
        end
      end
      exp_v = (q.size() > 0) && (q[0].due == cyc);
      vectors += 2;
      if (bus.resp_valid !== exp_v) begin
        miscompares++; $display("FAIL resp_valid cyc %0d: got %b want %b", cyc, bus.resp_valid, exp_v);
      end
      if ($isunknown(bus.resp_rdata)) begin
        miscompares++; $display("FAIL resp_rdata_known cyc %0d: got %h want no X/Z", cyc, bus.resp_rdata);
      end
      if (exp_v) begin
        vectors++;
        if (bus.resp_write !== q[0].req.write || bus.resp_error !== q[0].err ||
            bus.resp_rdata !== q[0].rdata) begin
          miscompares++;
          $display("FAIL resp cyc %0d: got w%b e%b %h want w%b e%b %h", cyc, bus.resp_write,
                   bus.resp_error, bus.resp_rdata, q[0].req.write, q[0].err, q[0].rdata);
        end
        void'(q.pop_front());
      end
    end
  end

  task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    int   guard;
    @(negedge clock);
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_addr = a; bus.req_wdata = d;
    guard = 0;
    while (bus.req_ready !== 1'b1 && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 20) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout: req_ready got %b want 1 within 20 cycles", bus.req_ready);
      bus.req_valid = 1'b0;
      return;
    end
    e.req   = '{write: w, addr: a, wdata: d};
    e.err   = 1'b0;
    e.rdata = w ? '0 : ref_mem[a];
    if (w) ref_mem[a] = d;
    e.acc   = cyc + 1;
    e.due   = (cyc + 3 > last_due + 1) ? cyc + 3 : last_due + 1;
    last_due = e.due;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      bus.req_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    vectors += 2;
    if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b0 || bus.resp_write !== 1'b0 ||
        bus.resp_error !== 1'b0 || bus.resp_rdata !== '0) begin
      miscompares++;
      $display("FAIL reset_bus: got rdy%b v%b w%b e%b %h want all 0", bus.req_ready,
               bus.resp_valid, bus.resp_write, bus.resp_error, bus.resp_rdata);
    end
    if (ram_chip_select !== 1'b0 || ram_we !== 1'b0 || ram_address !== '0 || ram_data_in !== '0) begin
      miscompares++;
      $display("FAIL reset_ram: got cs%b we%b a%0d d%h want all 0", ram_chip_select, ram_we,
               ram_address, ram_data_in);
    end
    reset = 1'b0;
    @(negedge clock);
    vectors++;
    if (bus.req_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_ready_rise: got %b want 1", bus.req_ready);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_write_read();
    send(1'b1, 11'd5, 32'hDEADBEEF);
    send(1'b0, 11'd5, 32'h0);
    idle(4);
    vectors++;
    if (q.size() != 0) begin
      miscompares++; $display("FAIL write_read_drain: got %0d pending want 0", q.size());
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < DEPTH; i++) send(1'b0, AW'($urandom_range(0, 15)), 32'h0);
    idle(5);
    vectors++;
    if (q.size() != 0) begin
      miscompares++; $display("FAIL back_to_back_drain: got %0d pending want 0", q.size());
    end
  endtask

  task automatic test_boundary();
    send(1'b1, 11'd0, 32'h0);
    send(1'b1, 11'd2047, 32'h1);
    send(1'b0, 11'd0, 32'hFFFF_FFFF);
    send(1'b0, 11'd2047, 32'hFFFF_FFFF);
    idle(5);
    vectors++;
    if (ref_mem[2047] !== 32'h1 || ram_mem[2047] !== 32'h1) begin
      miscompares++; $display("FAIL boundary_mem2047: got %h want 00000001", ram_mem[2047]);
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    for (int i = 0; i < 80; i++) begin
      a = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
      send(1'($urandom), a, $urandom);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(5);
  endtask

  task automatic test_out_of_range();
    int   a0;
    logic exp_v, exp_w;
    @(negedge clock);
    vectors++;
    if (bus_s.req_ready !== 1'b1) begin
      miscompares++; $display("FAIL oor_ready: got %b want 1", bus_s.req_ready);
    end
    bus_s.req_valid = 1'b1; bus_s.req_write = 1'b0; bus_s.req_addr = 11'd1500; bus_s.req_wdata = '0;
    a0 = cyc + 1;
    @(negedge clock);
    bus_s.req_write = 1'b1; bus_s.req_addr = 11'd1100; bus_s.req_wdata = 32'h1234_5678;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      bus_s.req_valid = 1'b0;
      exp_v = (cyc == a0 + 2) || (cyc == a0 + 3);
      exp_w = (cyc == a0 + 3);
      vectors += 2;
      if (s_ram_chip_select !== 1'b0 || s_ram_we !== 1'b0) begin
        miscompares++; $display("FAIL oor_cs cyc %0d: got cs%b we%b want 0 0", cyc, s_ram_chip_select, s_ram_we);
      end
      if (bus_s.resp_valid !== exp_v) begin
        miscompares++; $display("FAIL oor_valid cyc %0d: got %b want %b", cyc, bus_s.resp_valid, exp_v);
      end
      if (exp_v) begin
        vectors++;
        if (bus_s.resp_error !== 1'b1 || bus_s.resp_rdata !== '0 || bus_s.resp_write !== exp_w) begin
          miscompares++;
          $display("FAIL oor_resp cyc %0d: got e%b w%b %h want e1 w%b 0", cyc, bus_s.resp_error,
                   bus_s.resp_write, bus_s.resp_rdata, exp_w);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) send(1'b0, AW'($urandom_range(0, 15)), 32'h0);
    @(negedge clock);
    mon_en = 1'b0;
    reset = 1'b1;
    bus.req_valid = 1'b0;
    q.delete();
    last_due = 0;
    @(negedge clock);
    vectors++;
    if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b0 || bus.resp_rdata !== '0 ||
        ram_chip_select !== 1'b0 || ram_we !== 1'b0 || ram_address !== '0 || ram_data_in !== '0) begin
      miscompares++;
      $display("FAIL reset_mid: got rdy%b v%b %h cs%b we%b a%0d want all 0", bus.req_ready,
               bus.resp_valid, bus.resp_rdata, ram_chip_select, ram_we, ram_address);
    end
    reset = 1'b0;
    @(negedge clock);
    vectors++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_mid_after: got rdy%b v%b want 1 0", bus.req_ready, bus.resp_valid);
    end
    mon_en = 1'b1;
    idle(5);
  endtask

  initial begin
    int guard;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus_s.req_valid = 1'b0; bus_s.req_write = 1'b0; bus_s.req_addr = '0; bus_s.req_wdata = '0;
    ram_dout = 'z;
    for (int i = 0; i < 2048; i++) begin
      ram_mem[i] = '0;
      ref_mem[i] = '0;
    end
    test_reset();
    test_write_read();
    test_back_to_back();
    test_boundary();
    test_out_of_range();
    test_random();
    test_reset_mid();
    guard = 0;
    while (q.size() != 0 && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    vectors++;
    if (q.size() != 0) begin
      miscompares++; $display("FAIL final_drain: got %0d pending want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
